// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives PC to a combinational IMem, loads the
// instruction register with a one-entry handshake to the consumer, and handles redirects and halts.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instr_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ir_ready,
    output logic [31:0] PC,
    output logic [31:0] ir_out,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] ir_out_nxt;
    logic [31:0] ir_pc_nxt;
    logic        ir_valid_nxt;
    logic [15:0] count_nxt;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latches).
        state_nxt    = state;
        pc_nxt       = PC;
        ir_out_nxt   = ir_out;
        ir_pc_nxt    = ir_pc;
        ir_valid_nxt = ir_valid;
        count_nxt    = fetch_count;

        case (state)
            IDLE: begin
                if (redirect_valid) pc_nxt = redirect_pc;
                if (start)          state_nxt = FETCH;
            end
            FETCH: begin
                // A redirect squashes this cycle's word, even if it is the halt encoding.
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                end else if (instr_in == HALT_WORD) begin
                    state_nxt = HALT;
                end else begin
                    ir_out_nxt   = instr_in;
                    ir_pc_nxt    = PC;
                    pc_nxt       = PC + 32'd1;
                    ir_valid_nxt = 1'b1;
                    count_nxt    = (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;
                    state_nxt    = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) pc_nxt = redirect_pc;
                if (ir_valid && ir_ready) begin
                    ir_valid_nxt = 1'b0;
                    state_nxt    = FETCH;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            ir_out      <= 32'd0;
            ir_pc       <= 32'd0;
            ir_valid    <= 1'b0;
            fetch_count <= 16'd0;
        end else begin
            state       <= state_nxt;
            PC          <= pc_nxt;
            ir_out      <= ir_out_nxt;
            ir_pc       <= ir_pc_nxt;
            ir_valid    <= ir_valid_nxt;
            fetch_count <= count_nxt;
        end
    end

    assign halted = (state == HALT);

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, meaning the instruction encoding that stops fetching.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, a level that begins fetching from IDLE.
REQ-006 SHALL have port instr_in, input, 32, the instruction word returned combinationally by IMem for PC.
REQ-007 SHALL have port redirect_valid, input, 1, a branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32, the redirect target.
REQ-009 SHALL have port ir_ready, input, 1, asserted when the downstream consumer accepts IR.
REQ-010 SHALL have port PC, output, 32, the word address driven to the IMem PC input.
REQ-011 SHALL have port ir_out, output, 32, the instruction register.
REQ-012 SHALL have port ir_pc, output, 32, the PC from which ir_out was fetched.
REQ-013 SHALL have port ir_valid, output, 1, asserted while ir_out holds an unconsumed instruction.
REQ-014 SHALL have port halted, output, 1, asserted in state HALT.
REQ-015 SHALL have port fetch_count, output, 16, the number of IR loads since reset.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT, HALT; PC is registered, and IMem read is combinational from PC.
REQ-017 IDLE: PC held; start=1 -> FETCH next cycle.
REQ-018 FETCH, instr_in != HALT_WORD, no redirect: ir_out<=instr_in, ir_pc<=PC, PC<=PC+1, ir_valid<=1, fetch_count++, -> WAIT; IR load latency exactly 1 clock.
REQ-019 FETCH, instr_in == HALT_WORD, no redirect: IR, PC, ir_valid and fetch_count unchanged; -> HALT.
REQ-020 WAIT: ir_valid=1 and IR held stable until ir_ready=1; on ir_ready: ir_valid<=0, -> FETCH; ir_ready is ignored whenever ir_valid=0.
REQ-021 HALT: halted=1, PC held; start ignored; only a redirect or reset leaves HALT.
REQ-022 PC increment SHALL be modulo 2^32: 32'hFFFF_FFFF + 1 -> 32'h0000_0000.
REQ-023 fetch_count SHALL saturate at 16'hFFFF.
REQ-024 redirect_valid in FETCH: PC<=redirect_pc, no IR load, no count increment (squash), stay FETCH; redirect has priority over the HALT_WORD check.
REQ-025 redirect_valid in WAIT: PC<=redirect_pc; IR retained; state transition per REQ-020.
REQ-026 redirect_valid in HALT: PC<=redirect_pc, halted<=0, -> FETCH.
REQ-027 redirect_valid in IDLE: PC<=redirect_pc, stay IDLE.
REQ-028 Simultaneous start and redirect in IDLE: PC<=redirect_pc and -> FETCH.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force state IDLE, PC=RESET_PC, ir_out=0, ir_pc=0, ir_valid=0, halted=0, fetch_count=0.
REQ-030 Reset asserted mid-operation (any state) SHALL discard any pending IR and redirect; no transition occurs until the first clk edge after rst falls.

Verification
REQ-031 Sequential fetch: IMem[0..2]=A,B,C, start=1, ir_ready=1 whenever ir_valid=1 -> ir_out A/B/C with ir_pc 0/1/2 and fetch_count 3, one IR load every 2 cycles.
REQ-032 Backpressure: hold ir_ready=0 for 5 cycles after the first load -> ir_out=A, ir_valid=1, PC=1, fetch_count=1 throughout; fetch of B starts after ir_ready.
REQ-033 Halt: IMem[2]=32'hFFFF_FFFF -> after loading IMem[1], halted=1, PC=2, fetch_count=2, ir_valid=0; then redirect_pc=4 -> halted=0, next ir_pc=4.
REQ-034 Redirect in FETCH: redirect_pc=5 while PC=1 -> IMem[1] not loaded, next ir_pc=5, count unchanged by the squashed cycle.
REQ-035 Wrap: RESET_PC=32'hFFFF_FFFF, one fetch -> ir_pc=32'hFFFF_FFFF, PC=32'h0000_0000.
REQ-036 Async reset: assert rst between clock edges while in WAIT -> all outputs reach reset values before the next clk edge; state IDLE.
